// File: rtl/bwt_pkg.sv
// Shared definitions for the BWT back end: block length default, alphabet
// size and the move-to-front encoder state type.
package bwt_pkg;

  localparam int STRING_LEN_DEFAULT = 8;
  localparam int ALPHABET_SIZE      = 256;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ENCODE,
    DONE
  } mtf_state_t;

endpackage

// File: rtl/mtf_search.sv
// Combinational priority search: returns the lowest table index holding sym.
// The table is always a permutation of 0..255, so a match always exists.
module mtf_search
  import bwt_pkg::*;
(
  input  logic [8*ALPHABET_SIZE-1:0] tbl,
  input  logic [7:0]                 sym,
  output logic [7:0]                 pos
);

  always_comb begin
    pos = '0;
    // Scan from the top so the lowest matching index is the one that sticks.
    for (int i = ALPHABET_SIZE - 1; i >= 0; i--) begin
      if (tbl[8*i +: 8] == sym) begin
        pos = 8'(i);
      end
    end
  end

endmodule

// File: rtl/mtf_encoder.sv
// Move-to-front encoder for one BWT block: one symbol per cycle, also
// locating the primary index (position of the zero suffix).
module mtf_encoder
  import bwt_pkg::*;
#(
  parameter int STRING_LEN = STRING_LEN_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_mtf,
  input  logic [8*STRING_LEN-1:0] bwt_in,
  input  logic [8*STRING_LEN-1:0] suffixes_in,
  output logic [8*STRING_LEN-1:0] mtf_out,
  output logic [7:0]              primary_index,
  output logic                    idx_valid,
  output logic                    busy,
  output logic                    done
);

  localparam logic [7:0] LAST_PTR = 8'(STRING_LEN - 1);

  mtf_state_t state_reg, state_next;

  logic [8*STRING_LEN-1:0] bwt_reg;
  logic [8*STRING_LEN-1:0] suffixes_reg;
  logic [8*STRING_LEN-1:0] mtf_reg;
  logic [7:0]              ptr_reg;
  logic [7:0]              primary_index_reg;
  logic                    idx_valid_reg;
  logic [7:0]              tbl_reg [ALPHABET_SIZE];

  logic [8*ALPHABET_SIZE-1:0] tbl_flat;
  logic [7:0]                 sym;
  logic [7:0]                 pos;
  logic [7:0]                 cur_suffix;

  genvar gi;
  generate
    for (gi = 0; gi < ALPHABET_SIZE; gi++) begin : g_flat
      assign tbl_flat[8*gi +: 8] = tbl_reg[gi];
    end
  endgenerate

  assign sym        = bwt_reg[8*ptr_reg +: 8];
  assign cur_suffix = suffixes_reg[8*ptr_reg +: 8];

  mtf_search u_search (
    .tbl (tbl_flat),
    .sym (sym),
    .pos (pos)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_mtf) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        busy       = 1'b1;
        state_next = ENCODE;
      end
      ENCODE: begin
        busy = 1'b1;
        if (ptr_reg == LAST_PTR) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bwt_reg           <= '0;
      suffixes_reg      <= '0;
      mtf_reg           <= '0;
      ptr_reg           <= '0;
      primary_index_reg <= 8'hFF;
      idx_valid_reg     <= 1'b0;
      for (int i = 0; i < ALPHABET_SIZE; i++) begin
        tbl_reg[i] <= 8'(i);
      end
    end else begin
      case (state_reg)
        LOAD: begin
          bwt_reg           <= bwt_in;
          suffixes_reg      <= suffixes_in;
          ptr_reg           <= '0;
          primary_index_reg <= 8'hFF;
          idx_valid_reg     <= 1'b0;
          for (int i = 0; i < ALPHABET_SIZE; i++) begin
            tbl_reg[i] <= 8'(i);
          end
        end
        ENCODE: begin
          mtf_reg[8*ptr_reg +: 8] <= pos;
          // Shift entries 0..pos-1 up by one and put sym at the front; with
          // pos==0 this rewrites table[0] with the value it already holds.
          for (int i = 1; i < ALPHABET_SIZE; i++) begin
            if (i <= int'(pos)) begin
              tbl_reg[i] <= tbl_reg[i-1];
            end
          end
          tbl_reg[0] <= sym;
          if (cur_suffix == 8'h00 && !idx_valid_reg) begin
            primary_index_reg <= ptr_reg;
            idx_valid_reg     <= 1'b1;
          end
          if (ptr_reg != LAST_PTR) begin
            ptr_reg <= ptr_reg + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mtf_out       = mtf_reg;
  assign primary_index = primary_index_reg;
  assign idx_valid     = idx_valid_reg;

endmodule

// File: tb/tb_mtf_encoder.sv
// Randomized and directed checks of mtf_encoder against a queue-based
// move-to-front reference model.
module tb_mtf_encoder;

  localparam int N = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           start_mtf;
  logic [8*N-1:0] bwt_in;
  logic [8*N-1:0] suffixes_in;
  logic [8*N-1:0] mtf_out;
  logic [7:0]     primary_index;
  logic           idx_valid;
  logic           busy;
  logic           done;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  mtf_encoder #(.STRING_LEN(N)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_mtf     (start_mtf),
    .bwt_in        (bwt_in),
    .suffixes_in   (suffixes_in),
    .mtf_out       (mtf_out),
    .primary_index (primary_index),
    .idx_valid     (idx_valid),
    .busy          (busy),
    .done          (done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Reference: a list of all 256 byte values; each symbol's rank is its
  // position in the list, after which it is moved to the front.
  function automatic logic [8*N-1:0] ref_mtf(input logic [8*N-1:0] b);
    logic [7:0]     lst[$];
    logic [8*N-1:0] r;
    logic [7:0]     s;
    int             k;
    r = '0;
    for (int i = 0; i < 256; i++) lst.push_back(8'(i));
    for (int p = 0; p < N; p++) begin
      s = b[8*p +: 8];
      k = 0;
      while (lst[k] != s) k++;
      r[8*p +: 8] = 8'(k);
      lst.delete(k);
      lst.push_front(s);
    end
    return r;
  endfunction

  function automatic logic [8:0] ref_idx(input logic [8*N-1:0] s);
    for (int p = 0; p < N; p++) begin
      if (s[8*p +: 8] == 8'h00) return {1'b1, 8'(p)};
    end
    return {1'b0, 8'hFF};
  endfunction

  function automatic logic [8*N-1:0] rand_perm(input bit no_zero);
    int             a[N];
    int             j, t;
    logic [8*N-1:0] r;
    for (int i = 0; i < N; i++) a[i] = i;
    for (int i = N - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = a[i]; a[i] = a[j]; a[j] = t;
    end
    for (int i = 0; i < N; i++) r[8*i +: 8] = 8'(a[i] + (no_zero ? 1 : 0));
    return r;
  endfunction

  // Runs one block; scramble changes inputs after LOAD, poke pulses
  // start_mtf mid-encode and again on the DONE cycle.
  task automatic run_block(input string name, input logic [8*N-1:0] b,
                           input logic [8*N-1:0] s, input bit scramble, input bit poke);
    logic [8*N-1:0] exp_mtf;
    logic [8:0]     exp_idx;
    int             lat;
    exp_mtf = ref_mtf(b);
    exp_idx = ref_idx(s);
    @(negedge clk);
    bwt_in      = b;
    suffixes_in = s;
    start_mtf   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_mtf = 1'b0;
    check({name, "_busy_load"}, 64'(busy), 64'd1);
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      start_mtf = 1'b0;
      if (scramble) begin
        bwt_in      = {$urandom, $urandom};
        suffixes_in = {$urandom, $urandom};
      end
      if (poke && lat == 3) start_mtf = 1'b1;
    end
    // done is high in cycle T+N+2, i.e. N+1 edges after the sampling edge.
    check({name, "_latency"}, 64'(lat), 64'(N + 1));
    check({name, "_mtf"}, 64'(mtf_out), 64'(exp_mtf));
    check({name, "_pidx"}, 64'(primary_index), 64'(exp_idx[7:0]));
    check({name, "_valid"}, 64'(idx_valid), 64'(exp_idx[8]));
    if (poke) start_mtf = 1'b1;
    @(negedge clk);
    start_mtf = 1'b0;
    check({name, "_done_pulse"}, 64'(done), 64'd0);
    check({name, "_busy_after"}, 64'(busy), 64'd0);
    check({name, "_hold"}, 64'(mtf_out), 64'(exp_mtf));
  endtask

  initial begin
    logic [8*N-1:0] b, s;
    int             dc;

    rst = 1'b1; start_mtf = 1'b0; bwt_in = '0; suffixes_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_mtf", 64'(mtf_out), 64'd0);
    check("rst_pidx", 64'(primary_index), 64'hFF);
    check("rst_valid", 64'(idx_valid), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < N; i++) b[8*i +: 8] = (i % 2 == 0) ? 8'h61 : 8'h62;
    run_block("ident", b, rand_perm(1'b0), 1'b0, 1'b0);
    check("ident_const", 64'(mtf_out), 64'h0101010101016261);

    for (int i = 0; i < N; i++) b[8*i +: 8] = 8'h41;
    run_block("repeat", b, rand_perm(1'b0), 1'b0, 1'b0);
    check("repeat_const", 64'(mtf_out), 64'h0000000000000041);

    for (int i = 0; i < N; i++) b[8*i +: 8] = (i % 2 == 0) ? 8'hFF : 8'h00;
    for (int i = 0; i < N; i++) s[8*i +: 8] = (i == 5) ? 8'h00 : 8'(i + 10);
    run_block("bound", b, s, 1'b0, 1'b0);
    check("bound_const", 64'(mtf_out), 64'h01010101010101FF);
    check("bound_pidx5", 64'(primary_index), 64'd5);

    run_block("nozero", {$urandom, $urandom}, rand_perm(1'b1), 1'b0, 1'b0);
    check("nozero_pidx", 64'(primary_index), 64'hFF);

    // Abort at ptr==3: the reset edge falls inside the ptr==3 ENCODE cycle.
    @(negedge clk);
    bwt_in = {$urandom, $urandom}; suffixes_in = rand_perm(1'b0); start_mtf = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_mtf = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    dc  = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_mtf", 64'(mtf_out), 64'd0);
    check("abort_pidx", 64'(primary_index), 64'hFF);
    check("abort_valid", 64'(idx_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    repeat (15) @(negedge clk);
    check("abort_no_done", 64'(done_cnt), 64'(dc));

    // Reset wins over a coincident start.
    rst = 1'b1; start_mtf = 1'b1;
    @(negedge clk);
    rst = 1'b0; start_mtf = 1'b0;
    @(negedge clk);
    check("rst_prio_busy", 64'(busy), 64'd0);

    dc = done_cnt;
    run_block("poke", {$urandom, $urandom}, rand_perm(1'b0), 1'b0, 1'b1);
    repeat (15) @(negedge clk);
    check("poke_one_done", 64'(done_cnt - dc), 64'd1);

    for (int t = 0; t < 20; t++) begin
      b = {$urandom, $urandom};
      if (t % 3 == 0) for (int i = 0; i < N; i++) b[8*i +: 8] = 8'($urandom_range(0, 3));
      case (t % 3)
        0: s = rand_perm(1'b0);
        1: s = rand_perm(1'b1);
        default: for (int i = 0; i < N; i++) s[8*i +: 8] = 8'($urandom_range(0, 3));
      endcase
      run_block($sformatf("rnd%0d", t), b, s, t[0], 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mtf_encoder.md
MTF_ENCODER -- requirements
Module: mtf_encoder

Interface
REQ-001 Parameter: STRING_LEN, default 8, number of symbols per block; legal range 2..255.
REQ-002 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: start_mtf  input  1  single-cycle request to encode one block; sampled only in IDLE.
REQ-005 Port: bwt_in  input  8 x STRING_LEN  BWT output string from the upstream sorter.
REQ-006 Port: suffixes_in  input  8 x STRING_LEN  suffix array from the upstream sorter.
REQ-007 Port: mtf_out  output  8 x STRING_LEN  move-to-front ranks, one per input position.
REQ-008 Port: primary_index  output  8  position p where suffixes_in[p]==0.
REQ-009 Port: idx_valid  output  1  high when a zero suffix was found in the block.
REQ-010 Port: busy  output  1  high in LOAD and ENCODE.
REQ-011 Port: done  output  1  one-cycle pulse, high in DONE.

Function
REQ-012 FSM states SHALL be IDLE, LOAD, ENCODE and DONE, with these transitions:
- IDLE->LOAD on start_mtf.
- LOAD->ENCODE unconditionally.
- ENCODE->DONE when ptr==STRING_LEN-1.
- DONE->IDLE unconditionally.
REQ-013 LOAD SHALL do the following in one cycle:
- latch bwt_in and suffixes_in into internal registers;
- set the 256-entry table to identity, table[i]=i;
- set ptr=0, idx_valid=0 and primary_index=8'hFF.
REQ-014 ENCODE SHALL process one symbol per cycle: sym=bwt_reg[ptr], pos=lowest i with table[i]==sym, mtf_out[ptr]<=pos.
REQ-015 In the same ENCODE cycle the table SHALL update as follows: table[1..pos]<=table[0..pos-1], table[0]<=sym, entries above pos unchanged.
REQ-016 pos==0 SHALL leave the table unchanged.
REQ-017 In ENCODE, if suffixes_reg[ptr]==0, primary_index<=ptr and idx_valid<=1.
- Only the first match is recorded.
- ptr increments by 1 per cycle, 8-bit, and never wraps within a block.
REQ-018 Latency: start_mtf sampled at edge T gives LOAD in cycle T+1, ENCODE in cycles T+2..T+STRING_LEN+1, and done=1 in cycle T+STRING_LEN+2.
REQ-019 mtf_out, primary_index and idx_valid SHALL hold their values from DONE until the next LOAD.
REQ-020 start_mtf while not in IDLE SHALL be ignored, with no queuing.
REQ-021 start_mtf coincident with DONE SHALL be ignored; a new request is accepted only once IDLE is reached.
REQ-022 Inputs SHALL be read only in LOAD; changes to bwt_in or suffixes_in during ENCODE have no effect.
REQ-023 No zero suffix in the block SHALL give idx_valid=0 and primary_index=8'hFF at done.
REQ-024 Ranks SHALL be 8 bits wide; every byte value 0x00..0xFF is legal and no saturation occurs.

Reset
REQ-025 rst SHALL force, on the next edge: state=IDLE, busy=0, done=0, mtf_out all 0, primary_index=8'hFF, idx_valid=0, ptr=0, table=identity.
REQ-026 rst asserted mid-ENCODE SHALL abort the block with no done pulse; partial mtf_out is discarded (cleared to 0).
REQ-027 rst SHALL take priority over start_mtf in the same cycle.

Structure
REQ-028 Package bwt_pkg SHALL hold STRING_LEN default, ALPHABET_SIZE=256, and the mtf_state_t enum (IDLE, LOAD, ENCODE, DONE).
REQ-029 The priority search SHALL be a combinational sub-module mtf_search: 256x8 table plus sym in, 8-bit pos out.
REQ-030 The table and the shift SHALL live in mtf_encoder; RTL stays within 120-400 lines.

Verification
REQ-031 Identity check: bwt_in="abababab" (0x61/0x62 alternating) -> mtf_out={0x61,0x62,1,1,1,1,1,1}.
REQ-032 Repeat check: bwt_in all 0x41 -> mtf_out={0x41,0,0,0,0,0,0,0}.
REQ-033 Boundary symbols and index: bwt_in={0xFF,0x00,0xFF,0x00,...} with suffixes_in[5]==0 -> mtf_out={0xFF,1,1,1,1,1,1,1}, primary_index=5, idx_valid=1, and done exactly 10 cycles after the start_mtf edge.
REQ-034 Missing zero suffix: suffixes_in with no zero -> primary_index=8'hFF, idx_valid=0.
REQ-035 Abort and busy start: rst pulsed at ENCODE ptr=3 -> no done, outputs all 0; start_mtf pulsed while busy -> ignored, exactly one done pulse.
REQ-036 Back-to-back blocks: two consecutive blocks -> the second block's results are independent of the first, proving the table re-initialises in LOAD.
